// File: rtl/adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder/subtractor.
package adder_pkg;

  localparam int unsigned DefaultWidth  = 16;
  localparam int unsigned DefaultStages = 4;

  // Field view of one stage register at default size; the top keeps the same
  // fields but trims sum_done/a_rem/b_rem to their per-stage widths.
  typedef struct packed {
    logic                    valid;
    logic [DefaultWidth-1:0] sum_done;
    logic [DefaultWidth-1:0] a_rem;
    logic [DefaultWidth-1:0] b_rem;
    logic                    carry;
  } stage_t;

  function automatic int unsigned slice_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

  // Bit offset of stage k's leftover B' bits inside the packed remainder bus.
  function automatic int unsigned b_rem_offset(input int unsigned width,
                                               input int unsigned slice,
                                               input int unsigned k);
    return k * width - (slice * k * (k + 1)) / 2;
  endfunction

  function automatic int unsigned b_rem_total(input int unsigned width,
                                              input int unsigned stages);
    int unsigned total;
    total = (width * (stages - 1)) / 2;
    return (total == 0) ? 1 : total;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational ripple-carry adder for one pipeline slice.
module adder_slice #(
  parameter int unsigned Width = 4
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             carry_i,
  output logic [Width-1:0] sum_o,
  output logic             carry_o,
  output logic             carry_msb_o
);

  logic [Width:0] c;

  always_comb begin
    c     = '0;
    sum_o = '0;
    c[0]  = carry_i;
    for (int i = 0; i < Width; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign carry_o     = c[Width];
  assign carry_msb_o = c[Width-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor: one SLICE-bit ripple slice per stage, skewed operands,
// bubble-collapsing valid/ready flow control.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned STAGES = DefaultStages
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic             carry_in,
  input  logic             subtract,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : gen_bad_params
    $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
  end

  localparam int unsigned Slice = slice_width(WIDTH, STAGES);
  localparam int unsigned BRemW = b_rem_total(WIDTH, STAGES);

  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] carry;
  logic [STAGES-1:0] load;
  logic [WIDTH-1:0]  mix [STAGES];  // finished sum bits low, unprocessed A bits high
  logic [BRemW-1:0]  b_rem;         // unprocessed B' bits of every stage, packed
  logic [WIDTH-1:0]  b_eff;
  logic              cin0;

  assign b_eff = subtract ? ~input_b : input_b;
  assign cin0  = subtract | carry_in;

  // A stage may load if any stage at or below it has a bubble, or the sink accepts.
  always_comb begin
    logic bubble;
    bubble = 1'b0;
    load   = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      bubble  = bubble | ~valid[k];
      load[k] = bubble | out_ready;
    end
  end

  assign in_ready  = load[0];
  assign out_valid = valid[STAGES-1];
  assign sum       = mix[STAGES-1];
  assign carry_out = carry[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : gen_stage
    localparam int unsigned Lo   = k * Slice;
    localparam int unsigned Done = Lo + Slice;
    localparam int unsigned Rem  = WIDTH - Done;
    localparam int unsigned BOff = b_rem_offset(WIDTH, Slice, k);
    localparam int unsigned POff = (k == 0) ? 0 : b_rem_offset(WIDTH, Slice, k - 1);

    logic             v_in, c_in, s_cout, s_cmsb;
    logic [Slice-1:0] a_sl, b_sl, s_sum;
    logic [WIDTH-1:0] mix_d, mix_q;
    logic             v_q, c_q;

    if (k == 0) begin : gen_src_in
      assign v_in = in_valid;
      assign c_in = cin0;
      assign a_sl = input_a[Slice-1:0];
      assign b_sl = b_eff[Slice-1:0];
    end else begin : gen_src_prev
      assign v_in          = valid[k-1];
      assign c_in          = carry[k-1];
      assign a_sl          = mix[k-1][Lo +: Slice];
      assign b_sl          = b_rem[POff +: Slice];
      assign mix_d[Lo-1:0] = mix[k-1][Lo-1:0];
    end

    adder_slice #(
      .Width(Slice)
    ) u_slice (
      .a_i        (a_sl),
      .b_i        (b_sl),
      .carry_i    (c_in),
      .sum_o      (s_sum),
      .carry_o    (s_cout),
      .carry_msb_o(s_cmsb)
    );

    assign mix_d[Lo +: Slice] = s_sum;

    if (Rem > 0) begin : gen_rem
      logic [Rem-1:0] b_rem_d, b_rem_q;

      if (k == 0) begin : gen_from_in
        assign mix_d[WIDTH-1:Done] = input_a[WIDTH-1:Done];
        assign b_rem_d             = b_eff[WIDTH-1:Done];
      end else begin : gen_from_prev
        assign mix_d[WIDTH-1:Done] = mix[k-1][WIDTH-1:Done];
        assign b_rem_d             = b_rem[POff + Slice +: Rem];
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          b_rem_q <= '0;
        end else if (load[k] && v_in) begin
          b_rem_q <= b_rem_d;
        end
      end

      assign b_rem[BOff +: Rem] = b_rem_q;
    end

    // Data only moves with a valid beat so the output stage keeps its last result.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        mix_q <= '0;
      end else if (load[k]) begin
        v_q <= v_in;
        if (v_in) begin
          c_q   <= s_cout;
          mix_q <= mix_d;
        end
      end
    end

    assign valid[k] = v_q;
    assign carry[k] = c_q;
    assign mix[k]   = mix_q;

    if (k == STAGES - 1) begin : gen_ovf
      logic ovf_q;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          ovf_q <= 1'b0;
        end else if (load[k] && v_in) begin
          ovf_q <= s_cmsb ^ s_cout;
        end
      end
      assign overflow = ovf_q;
    end else begin : gen_no_ovf
      logic unused_cmsb;
      assign unused_cmsb = s_cmsb;
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench: 16-bit/4-stage directed + random run, then exhaustive 4-bit runs
// with 2 and 1 stages under random backpressure.
module tb_pipelined_adder;

  localparam int unsigned W0 = 16;
  localparam int unsigned S0 = 4;

  typedef struct {
    logic [15:0] sum;
    logic        co;
    logic        ov;
    int          t;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;
  logic small_go = 1'b0;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Plain-arithmetic reference: A + B' + cin over w bits, overflow from operand/result signs.
  function automatic exp_t model(input int unsigned w, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub, input int t);
    longint unsigned mask, aa, bb, full;
    exp_t            e;
    mask = (64'd1 << w) - 64'd1;
    aa   = longint'(a) & mask;
    bb   = longint'(b) & mask;
    if (sub) bb = ~bb & mask;
    full  = aa + bb + ((sub || cin) ? 64'd1 : 64'd0);
    e.sum = 16'(full & mask);
    e.co  = full[w];
    e.ov  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    e.t   = t;
    return e;
  endfunction

  // ---------------- main DUT: WIDTH=16, STAGES=4 ----------------
  logic        v0, r0, c0, s0, ov0, ordy0, co0, of0, rnd0;
  logic [15:0] a0, b0, sum0;
  exp_t        q0[$];
  int          pushes0 = 0, pops0 = 0;
  bit          saw_full0 = 0;

  pipelined_adder #(
    .WIDTH (W0),
    .STAGES(S0)
  ) u_dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (v0),
    .in_ready (r0),
    .input_a  (a0),
    .input_b  (b0),
    .carry_in (c0),
    .subtract (s0),
    .out_valid(ov0),
    .out_ready(ordy0),
    .sum      (sum0),
    .carry_out(co0),
    .overflow (of0)
  );

  always @(posedge clock) begin
    #1;
    if (rnd0) ordy0 = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clock) begin
    if (!reset_n) begin
      q0.delete();
    end else begin
      check("in_ready", 32'(r0), 32'((q0.size() < S0) || ordy0));
      if (!r0) saw_full0 = 1;
      if (ov0) begin
        if (q0.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out: actual sum=%0h required=no beat", sum0);
        end else begin
          check("sum", 32'(sum0), 32'(q0[0].sum));
          check("carry_out", 32'(co0), 32'(q0[0].co));
          check("overflow", 32'(of0), 32'(q0[0].ov));
          if (ordy0) begin
            check("latency_min", 32'((cycle - q0[0].t) >= S0), 32'd1);
            void'(q0.pop_front());
            pops0++;
          end
        end
      end
      if (v0 && r0) begin
        q0.push_back(model(W0, a0, b0, c0, s0, cycle));
        pushes0++;
      end
    end
  end

  // Call #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send0(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
    int n;
    a0 = a; b0 = b; c0 = ci; s0 = sb; v0 = 1'b1;
    n = 0;
    @(negedge clock);
    while (!r0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("accept_in_time", 32'(n < 100), 32'd1);
    @(posedge clock);
    #1;
    v0 = 1'b0;
  endtask

  task automatic drain0();
    int n;
    n = 0;
    while (q0.size() != 0 && n < 300) begin
      @(posedge clock);
      n++;
    end
    #1;
    check("drain", 32'(q0.size()), 32'd0);
  endtask

  task automatic latency0(input string name);
    int n;
    n = 0;
    while (!ov0 && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    check(name, 32'(n + 1), 32'(S0));
  endtask

  // ---------------- exhaustive 4-bit DUTs: STAGES=2 and STAGES=1 ----------------
  for (genvar g = 0; g < 2; g++) begin : gen_small
    localparam int unsigned ST = (g == 0) ? 2 : 1;
    logic       v, r, c, s, ov, ordy, co, of;
    logic [3:0] a, b, sm;
    exp_t       q[$];
    bit         drain = 0;
    bit         done  = 0;

    pipelined_adder #(
      .WIDTH (4),
      .STAGES(ST)
    ) u_dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .in_valid (v),
      .in_ready (r),
      .input_a  (a),
      .input_b  (b),
      .carry_in (c),
      .subtract (s),
      .out_valid(ov),
      .out_ready(ordy),
      .sum      (sm),
      .carry_out(co),
      .overflow (of)
    );

    always @(posedge clock) begin
      #1;
      if (small_go && !drain) ordy = ($urandom_range(0, 2) != 0);
    end

    always @(negedge clock) begin
      if (!reset_n) begin
        q.delete();
      end else begin
        check($sformatf("s%0d_in_ready", ST), 32'(r), 32'((q.size() < ST) || ordy));
        if (ov) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL s%0d_spurious_out: actual sum=%0h required=no beat", ST, sm);
          end else begin
            check($sformatf("s%0d_sum", ST), 32'(sm), 32'(q[0].sum));
            check($sformatf("s%0d_carry_out", ST), 32'(co), 32'(q[0].co));
            check($sformatf("s%0d_overflow", ST), 32'(of), 32'(q[0].ov));
            if (ordy) begin
              check($sformatf("s%0d_latency_min", ST), 32'((cycle - q[0].t) >= ST), 32'd1);
              void'(q.pop_front());
            end
          end
        end
        if (v && r) q.push_back(model(4, {12'd0, a}, {12'd0, b}, c, s, cycle));
      end
    end

    initial begin
      int n;
      v = 1'b0; a = '0; b = '0; c = 1'b0; s = 1'b0; ordy = 1'b1;
      wait (small_go);
      @(posedge clock);
      #1;
      for (int i = 0; i < 1024; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clock);
          #1;
        end
        {a, b, c, s} = 10'(i);
        v = 1'b1;
        n = 0;
        @(negedge clock);
        while (!r && n < 100) begin
          @(negedge clock);
          n++;
        end
        check($sformatf("s%0d_accept_in_time", ST), 32'(n < 100), 32'd1);
        @(posedge clock);
        #1;
        v = 1'b0;
      end
      #2;
      drain = 1;
      ordy  = 1'b1;
      n = 0;
      while (q.size() != 0 && n < 100) begin
        @(posedge clock);
        n++;
      end
      #1;
      check($sformatf("s%0d_drain", ST), 32'(q.size()), 32'd0);
      done = 1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    reset_n = 1'b0;
    v0 = 1'b0; a0 = '0; b0 = '0; c0 = 1'b0; s0 = 1'b0; ordy0 = 1'b1; rnd0 = 1'b0;
    #12;
    check("rst_out_valid", 32'(ov0), 32'd0);
    check("rst_sum", 32'(sum0), 32'd0);
    check("rst_carry_out", 32'(co0), 32'd0);
    check("rst_overflow", 32'(of0), 32'd0);
    @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("rst_in_ready", 32'(r0), 32'd1);

    // Carry ripples through every slice; also the unstalled latency.
    send0(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    latency0("latency_first");
    send0(16'h8000, 16'h0001, 1'b0, 1'b1);
    send0(16'h0000, 16'h0001, 1'b0, 1'b1);
    send0(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send0(16'h1234, 16'h0000, 1'b1, 1'b0);
    send0(16'h0005, 16'h0003, 1'b1, 1'b1);
    drain0();

    // Back-to-back burst with a 6-cycle sink stall in the middle.
    saw_full0 = 0;
    pushes0   = 0;
    pops0     = 0;
    fork
      for (int i = 0; i < 10; i++)
        send0(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      begin
        repeat (3) @(posedge clock);
        #1 ordy0 = 1'b0;
        repeat (6) @(posedge clock);
        #1 ordy0 = 1'b1;
      end
    join
    drain0();
    check("burst_stall_seen", 32'(saw_full0), 32'd1);
    check("burst_pushes", 32'(pushes0), 32'd10);
    check("burst_pops", 32'(pops0), 32'd10);

    // Random operands under random backpressure.
    rnd0 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock);
        #1;
      end
      send0(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    #2;
    rnd0  = 1'b0;
    ordy0 = 1'b1;
    drain0();

    // Asynchronous reset with beats in flight.
    @(posedge clock);
    #1 ordy0 = 1'b0;
    for (int i = 0; i < 3; i++)
      send0(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    repeat (4) @(posedge clock);
    #3;
    check("pre_reset_out_valid", 32'(ov0), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(ov0), 32'd0);
    check("async_rst_sum", 32'(sum0), 32'd0);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    ordy0   = 1'b1;
    @(posedge clock);
    #1;
    send0(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
    latency0("latency_after_reset");
    drain0();

    small_go = 1'b1;
    n = 0;
    while (!(gen_small[0].done && gen_small[1].done) && n < 20000) begin
      @(posedge clock);
      n++;
    end
    check("small_runs_done", 32'(gen_small[0].done && gen_small[1].done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule
